pc_fetch_ctrl: RTL and testbench

- Fetch sequencer between the PC-next selection logic and instruction memory.
- Owns the architectural fetch PC and issues one instruction-memory request at a time over a req/gnt/rvalid handshake.
- Presents fetched instructions to decode over a valid/ready handshake.
- Applies redirects (JAL, JALR, taken branch) from the PC-next path, killing stale fetches in flight.

---
 rtl/pc_fetch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch sequencer owning the fetch PC, one imem request in
// flight (req/gnt/rvalid), decode-side valid/ready, redirect with kill.
// Ports: clk, rst (sync, active-high); redirect_valid/redirect_pc from
//   PC-next; imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata to memory;
//   if_valid/if_instr/if_pc/if_ready to decode; misalign_err sticky flag.
// Option: define MISALIGN_TRAP_EN to trap on misaligned redirect targets
//   (S_TRAP, sticky misalign_err); otherwise targets are forced aligned.
module pc_fetch_ctrl #(
  parameter int                   DATAWIDTH = 32,
  parameter logic [DATAWIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [DATAWIDTH-1:0] redirect_pc,
  output logic                 imem_req,
  output logic [DATAWIDTH-1:0] imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [31:0]          imem_rdata,
  output logic                 if_valid,
  output logic [31:0]          if_instr,
  output logic [DATAWIDTH-1:0] if_pc,
  input  logic                 if_ready,
  output logic                 misalign_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
`ifdef MISALIGN_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                 kill_q, kill_d;
  logic [31:0]          instr_q, instr_d;
  logic [DATAWIDTH-1:0] ipc_q, ipc_d;
  logic                 redir_en;
  logic [DATAWIDTH-1:0] tgt;

  // Low two bits cleared: word-aligned target.
  assign tgt = redirect_pc & ~(DATAWIDTH'(3));

`ifdef MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  logic mis_tgt;
  assign mis_tgt  = (redirect_pc[1:0] != 2'b00);
  assign redir_en = redirect_valid && (state_q != S_TRAP);
  assign misalign_err = mis_q;
`else
  assign redir_en = redirect_valid;
  assign misalign_err = 1'b0;
`endif

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = fetch_pc_q;
  assign if_valid  = (state_q == S_HOLD);
  assign if_instr  = instr_q;
  assign if_pc     = ipc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
`ifdef MISALIGN_TRAP_EN
    mis_d      = mis_q;
`endif

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d    = imem_rdata;
            ipc_d      = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + DATAWIDTH'(4);
            state_d    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (if_ready) state_d = S_REQ;
      end
`ifdef MISALIGN_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides the normal flow; the one outstanding
    // response (if any) must be discarded via kill.
    if (redir_en) begin
      fetch_pc_d = tgt;
      unique case (state_q)
        S_REQ: begin
          if (imem_gnt) kill_d = 1'b1;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            instr_d = instr_q;
            ipc_d   = ipc_q;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end
        S_HOLD: state_d = S_REQ;
        default: ;
      endcase
`ifdef MISALIGN_TRAP_EN
      if (mis_tgt) begin
        fetch_pc_d = redirect_pc;
        mis_d      = 1'b1;
        kill_d     = 1'b0;
        instr_d    = instr_q;
        ipc_d      = ipc_q;
        state_d    = S_TRAP;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      kill_q     <= 1'b0;
      instr_q    <= '0;
      ipc_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed bench for pc_fetch_ctrl with a memory model
// and scoreboard queues for grant addresses and decode handshakes.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b0;
  logic        misalign_err;

  pc_fetch_ctrl dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .if_valid(if_valid),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .if_ready(if_ready),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp_ins[$];

  bit          gnt_en = 1'b1;
  bit          ovr_en = 1'b0;
  int          rv_delay = 0;
  bit          pend = 1'b0;
  int          dly = 0;
  logic [31:0] paddr = '0;

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!if_valid && n < 30) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, if_valid}, 32'd1);
  endtask

  task automatic push_if(input logic [31:0] pc);
    exp_pc.push_back(pc);
    exp_ins.push_back(fdat(pc));
  endtask

  // Memory: grant whenever enabled, respond rv_delay+1 cycles after grant.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    imem_gnt = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (dly == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = ovr_en ? 32'hDEAD_BEEF : fdat(paddr);
          pend = 1'b0;
        end else begin
          dly--;
        end
      end
      if (gnt_en && imem_req && !pend) begin
        imem_gnt = 1'b1;
        pend = 1'b1;
        dly = rv_delay;
        paddr = imem_addr;
        if (exp_addr.size() == 0) begin
          n_cmp++;
          n_fail++;
          $error("FAIL gnt_unexpected: got %h expected none", imem_addr);
        end else begin
          chk("gnt_addr", imem_addr, exp_addr.pop_front());
        end
      end
    end
  end

  // Decode-side handshake monitor.
  always @(negedge clk) begin
    if (!rst && if_valid && if_ready) begin
      if (exp_pc.size() == 0) begin
        n_cmp++;
        n_fail++;
        $error("FAIL if_dup: got pc %h expected no handshake", if_pc);
      end else begin
        chk("if_pc", if_pc, exp_pc.pop_front());
        chk("if_instr", if_instr, exp_ins.pop_front());
      end
    end
  end

  initial begin
    bit saw;
    int n;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_mis", {31'b0, misalign_err}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);

    exp_addr.push_back(32'h0);
    rst = 1'b0;
    wait_valid("first_valid");

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", {31'b0, if_valid}, 32'd1);
      chk("hold_req", {31'b0, imem_req}, 32'd0);
      chk("hold_pc", if_pc, 32'h0);
      chk("hold_instr", if_instr, fdat(32'h0));
    end

    push_if(32'h0);
    push_if(32'h4);
    push_if(32'h8);
    exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h8);
    exp_addr.push_back(32'hC);
    if_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("pulse", {31'b0, if_valid}, {31'b0, (i % 3 == 0)});
      if (i == 9) if_ready = 1'b0;
    end
    chk("pulse_pc", if_pc, 32'hC);

    push_if(32'hC);
    exp_addr.push_back(32'h10);
    exp_addr.push_back(32'h100);
    rv_delay = 2;
    if_ready = 1'b1;
    tick();
    tick();
    chk("in_wait", {31'b0, imem_req}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    ovr_en = 1'b1;
    if_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    rv_delay = 0;
    saw = 1'b0;
    n = 0;
    while (!imem_req && n < 20) begin
      if (if_valid) saw = 1'b1;
      tick();
      n++;
    end
    ovr_en = 1'b0;
    chk("kill_novalid", {31'b0, saw}, 32'd0);
    chk("kill_addr", imem_addr, 32'h100);

    push_if(32'h100);
    wait_valid("v100");
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    if_ready = 1'b1;
    exp_addr.push_back(32'h200);
    tick();
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    chk("hredir_valid", {31'b0, if_valid}, 32'd0);
    chk("hredir_addr", imem_addr, 32'h200);

    push_if(32'h200);
    wait_valid("v200");
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    if_ready = 1'b1;
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0);
    push_if(32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    wait_valid("vwrap");
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_req", {31'b0, imem_req}, 32'd1);
    wait_valid("v0");

    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
    chk("trap_mis", {31'b0, misalign_err}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("trap_req", {31'b0, imem_req}, 32'd0);
      chk("trap_valid", {31'b0, if_valid}, 32'd0);
      tick();
    end
`else
    chk("mis_flag", {31'b0, misalign_err}, 32'd0);
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_req", {31'b0, imem_req}, 32'd1);
    gnt_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    chk("req_redir_addr", imem_addr, 32'h300);
    chk("req_redir_req", {31'b0, imem_req}, 32'd1);
    exp_addr.push_back(32'h300);
    push_if(32'h300);
    gnt_en = 1'b1;
    wait_valid("v300");
    if_ready = 1'b1;
    gnt_en = 1'b0;
    tick();
    if_ready = 1'b0;
    chk("consumed", {31'b0, if_valid}, 32'd0);
    tick();
    tick();
`endif

    chk("addr_q_empty", exp_addr.size(), 32'd0);
    chk("if_q_empty", exp_pc.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
